alu32: RTL and testbench
========================

// Module: alu32
// PURPOSE
// - 32-bit integer ALU for the datapath execute stage: AND, OR, ADD, NOR, XOR, SUB on operands a/b.
// - Also produces an a<b compare flag and an overflow flag; all results are registered (1-cycle latency).
// - Signedness is selected per cycle by unsig: unsig=1 -> signed (two's complement), unsig=0 -> unsigned.
// PARAMETERS
// - WIDTH   32   operand/result width (all behaviour below stated for 32)
// PORTS
// - clk       in   1      single clock, rising edge
// - rst       in   1      reset, asynchronous, active-high
// - a         in   32     operand A
// - b         in   32     operand B
// - op        in   3      operation select (encoding below)
// - unsig     in   1      1 = signed (two's complement), 0 = unsigned
// - aluout    out  32     registered result
// - compout   out  1      registered compare flag: a < b under current signedness
// - overflow  out  1      registered overflow flag for ADD/SUB, else 0
// BEHAVIOUR
// - Interface: one clock, clk; reset rst is asynchronous and active-high.
// - Op encoding: 000 AND, 001 OR, 010 ADD (a+b), 100 NOR ~(a|b), 101 XOR, 110 SUB (a-b).
// - Undefined ops 011 and 111: aluout=0, overflow=0; compout still valid.
// - Result width: ADD/SUB wrap modulo 2^32; aluout = low 32 bits in both signed and unsigned modes.
// - Overflow, unsigned (unsig=0): ADD -> carry out of bit 31; SUB -> borrow (a < b unsigned).
// - Overflow, signed (unsig=1): ADD -> a[31]==b[31] && res[31]!=a[31]; SUB -> a[31]!=b[31] && res[31]!=a[31].
// - Logic ops (AND/OR/NOR/XOR) always overflow=0, regardless of unsig.
// - compout: signed or unsigned a<b per unsig, computed every cycle independent of op.
// - Timing: combinational compute of a/b/op/unsig sampled at rising clk; outputs update on that edge (latency 1).
// - No handshake; a new operation is accepted every cycle, back-to-back.
// - Reset: while rst=1 (asynchronously on assertion) aluout=0, compout=0, overflow=0.
// - Reset mid-operation: in-flight result discarded; first valid result is from the first edge after rst deasserts.
// - Unknown/X inputs need no special handling; outputs follow the equations above.
// STRUCTURE
// - Shared package alu_pkg: localparams OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010,
//   OP_NOR=3'b100, OP_XOR=3'b101, OP_SUB=3'b110; ALU_W=32.
// - One sub-module, alu32_addsub: 33-bit add/sub (b inverted + carry-in for SUB).
//   Outputs: sum, carry/borrow, signed overflow.
// - Top level holds the logic ops, op mux, compare, and output registers.
// TESTING
// - Logic: a=F0F0F0F0 b=FF00FF00, ops 000/001/100/101 -> aluout F000F000/FFF0FFF0/000F000F/0FF00FF0, overflow=0.
// - Unsigned ADD: a=FFFFFFFF b=00000001 unsig=0 op=010 -> aluout=0, overflow=1, compout=0.
//   Same with unsig=1 -> aluout=0, overflow=0, compout=1.
// - Signed ADD: a=7FFFFFFF b=00000001 unsig=1 -> aluout=80000000, overflow=1, compout=0.
// - SUB: a=1 b=2 op=110 -> aluout=FFFFFFFF; unsig=0 -> overflow=1, compout=1; unsig=1 -> overflow=0, compout=1.
//   Signed a=80000000 b=1 -> aluout=7FFFFFFF, overflow=1.
// - Latency/reset: drive a new vector each cycle; outputs match the previous edge's inputs.
//   Assert rst mid-stream -> outputs 0 immediately, with no clock edge needed.
//   Release rst -> correct result after the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and datapath width.
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;

endpackage

// File: rtl/alu32_addsub.sv
// Shared adder/subtractor: one (WIDTH+1)-bit add, with b inverted plus carry-in for SUB.
module alu32_addsub import alu_pkg::*; #(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             sovf
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   full;

  assign bx   = b ^ {WIDTH{sub}};
  assign full = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  assign sum  = full[WIDTH-1:0];

  // For SUB the raw carry-out means "no borrow", so invert it to report a borrow.
  assign carry = full[WIDTH] ^ sub;
  assign sovf  = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu32.sv
// Execute-stage ALU: logic ops, add/sub, compare and overflow, all registered.
module alu32 import alu_pkg::*; #(
  parameter int unsigned WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             unsig,
  output logic [WIDTH-1:0] aluout,
  output logic             compout,
  output logic             overflow
);

  logic             sub;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             sovf;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic             lt;

  assign sub = (op == OP_SUB);

  alu32_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (a),
    .b     (b),
    .sub   (sub),
    .sum   (sum),
    .carry (carry),
    .sovf  (sovf)
  );

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_NOR: res = ~(a | b);
      OP_XOR: res = a ^ b;
      OP_ADD, OP_SUB: begin
        res = sum;
        ovf = unsig ? sovf : carry;
      end
      default: begin
        res = '0;
        ovf = 1'b0;
      end
    endcase
  end

  // unsig=1 selects two's-complement comparison.
  assign lt = unsig ? ($signed(a) < $signed(b)) : (a < b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluout   <= '0;
      compout  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      aluout   <= res;
      compout  <= lt;
      overflow <= ovf;
    end
  end

endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: directed vectors, reset behaviour and randomized ops vs. a reference model.
module tb_alu32;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        unsig;
  logic [31:0] aluout;
  logic        compout;
  logic        overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  alu32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .op       (op),
    .unsig    (unsig),
    .aluout   (aluout),
    .compout  (compout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model from arithmetic on wide signed/unsigned integers.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [2:0] mop,
                       input logic mu, output logic [31:0] r, output logic c, output logic o);
    longint ua, ub, sa, sb, t;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    r = 32'h0;
    o = 1'b0;
    case (mop)
      3'd0: r = ma & mb;
      3'd1: r = ma | mb;
      3'd4: r = ~(ma | mb);
      3'd5: r = ma ^ mb;
      3'd2: begin
        t = ua + ub;
        r = t[31:0];
        if (mu) o = (sa + sb > 64'sd2147483647) || (sa + sb < -64'sd2147483648);
        else    o = (t > 64'sd4294967295);
      end
      3'd6: begin
        t = ua - ub;
        r = t[31:0];
        if (mu) o = (sa - sb > 64'sd2147483647) || (sa - sb < -64'sd2147483648);
        else    o = (ua < ub);
      end
      default: r = 32'h0;
    endcase
    c = mu ? (sa < sb) : (ua < ub);
  endtask

  // Drive a vector (caller is just after a rising edge), then check after the next edge.
  task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic [2:0] vop, input logic vu);
    logic [31:0] er;
    logic ec, eo;
    a = va; b = vb; op = vop; unsig = vu;
    model(va, vb, vop, vu, er, ec, eo);
    @(posedge clk);
    #1;
    check({tag, ".aluout"}, aluout, er);
    check({tag, ".compout"}, {31'b0, compout}, {31'b0, ec});
    check({tag, ".overflow"}, {31'b0, overflow}, {31'b0, eo});
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".aluout"}, aluout, 32'h0);
    check({tag, ".compout"}, {31'b0, compout}, 32'h0);
    check({tag, ".overflow"}, {31'b0, overflow}, 32'h0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    a = 32'h0; b = 32'h0; op = 3'd0; unsig = 1'b0;
    #2;
    check_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_held");
    rst = 1'b0;

    // Spec-called-out vectors
    run_vec("and", 32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 1'b0);
    check("and.value", aluout, 32'hF000F000);
    run_vec("or",  32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 1'b1);
    check("or.value", aluout, 32'hFFF0FFF0);
    run_vec("nor", 32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 1'b0);
    check("nor.value", aluout, 32'h000F000F);
    run_vec("xor", 32'hF0F0F0F0, 32'hFF00FF00, 3'b101, 1'b1);
    check("xor.value", aluout, 32'h0FF00FF0);
    run_vec("addu", 32'hFFFFFFFF, 32'h00000001, 3'b010, 1'b0);
    check("addu.ovf", {31'b0, overflow}, 32'h1);
    run_vec("adds_neg1", 32'hFFFFFFFF, 32'h00000001, 3'b010, 1'b1);
    check("adds_neg1.cmp", {31'b0, compout}, 32'h1);
    run_vec("adds_ovf", 32'h7FFFFFFF, 32'h00000001, 3'b010, 1'b1);
    check("adds_ovf.value", aluout, 32'h80000000);
    run_vec("subu", 32'h1, 32'h2, 3'b110, 1'b0);
    check("subu.ovf", {31'b0, overflow}, 32'h1);
    run_vec("subs", 32'h1, 32'h2, 3'b110, 1'b1);
    check("subs.value", aluout, 32'hFFFFFFFF);
    run_vec("subs_ovf", 32'h80000000, 32'h1, 3'b110, 1'b1);
    check("subs_ovf.value", aluout, 32'h7FFFFFFF);
    run_vec("undef3", 32'h12345678, 32'h9ABCDEF0, 3'b011, 1'b1);
    run_vec("undef7", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111, 1'b0);

    // Reset asserted mid-stream clears outputs without a clock edge
    run_vec("pre_rst", 32'hFFFFFFFF, 32'h00000001, 3'b010, 1'b0);
    rst = 1'b1;
    #1;
    check_zero("rst_midstream");
    a = 32'hDEADBEEF; b = 32'h1; op = 3'b001;
    @(posedge clk);
    #1;
    check_zero("rst_edge_held");
    rst = 1'b0;
    run_vec("post_rst", 32'h80000000, 32'h00000001, 3'b110, 1'b1);

    // Randomized back-to-back traffic
    for (int i = 0; i < 400; i++) begin
      run_vec("rand", pick_operand(), pick_operand(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
